// File: rtl/phase_sequencer_if.sv
// Phase strobes from the sequencer to the datapath blocks and the decode/status signals it reads back.
interface phase_sequencer_if #(
  parameter int WORD_SIZE = 16,
  parameter int NIB_SIZE  = 4
);
  logic                 run;
  logic [NIB_SIZE-1:0]  opcode;
  logic                 isaluop;
  logic                 br_taken;
  logic                 mem_ready;
  logic                 do_fetch;
  logic                 do_regload;
  logic                 do_aluop;
  logic                 do_memload;
  logic                 do_memstore;
  logic                 do_regstore;
  logic                 do_next;
  logic                 take_branch;
  logic                 busy;
  logic                 timeout_err;
  logic [WORD_SIZE-1:0] retired;

  modport master (
    input  run, opcode, isaluop, br_taken, mem_ready,
    output do_fetch, do_regload, do_aluop, do_memload, do_memstore,
           do_regstore, do_next, take_branch, busy, timeout_err, retired
  );

  modport slave (
    output run, opcode, isaluop, br_taken, mem_ready,
    input  do_fetch, do_regload, do_aluop, do_memload, do_memstore,
           do_regstore, do_next, take_branch, busy, timeout_err, retired
  );
endinterface

// File: rtl/phase_sequencer.sv
// Steps each instruction through fetch/regload/exec/[memwait]/[regstore]/next with one-cycle strobes.
// Latency 4-6 cycles plus port wait states; mem_ready stretches MEMWAIT, MEM_TIMEOUT cycles without it -> FAULT.
module phase_sequencer #(
  parameter int                  WORD_SIZE   = 16,
  parameter int                  NIB_SIZE    = 4,
  parameter int                  MEM_TIMEOUT = 15,
  parameter logic [NIB_SIZE-1:0] OP_LOADLO   = NIB_SIZE'(1),
  parameter logic [NIB_SIZE-1:0] OP_LOADHI   = NIB_SIZE'(2),
  parameter logic [NIB_SIZE-1:0] OP_IN       = NIB_SIZE'(3),
  parameter logic [NIB_SIZE-1:0] OP_OUT      = NIB_SIZE'(4),
  parameter logic [NIB_SIZE-1:0] OP_JMP      = NIB_SIZE'(5),
  parameter logic [NIB_SIZE-1:0] OP_BR       = NIB_SIZE'(6)
) (
  input  logic                 clk,
  input  logic                 do_reset,
  phase_sequencer_if.master    bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_REGLOAD, S_EXEC, S_MEMWAIT, S_REGSTORE, S_NEXT, S_FAULT
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [WORD_SIZE-1:0] retired_q;
  logic                 fetch_q, regload_q, aluop_q, memload_q, memstore_q;
  logic                 regstore_q, next_q, busy_q, timeout_q;

  logic op_in, op_out, op_jmp, op_br, writes_reg;

  assign op_in      = (bus.opcode == OP_IN);
  assign op_out     = (bus.opcode == OP_OUT);
  assign op_jmp     = (bus.opcode == OP_JMP);
  assign op_br      = (bus.opcode == OP_BR);
  assign writes_reg = bus.isaluop | (bus.opcode == OP_LOADLO) | (bus.opcode == OP_LOADHI) | op_in;

  // Strobes are registered together with the state they belong to, so each one
  // is set on the transition into its state and cleared by default otherwise.
  always_ff @(posedge clk) begin
    if (do_reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      retired_q  <= '0;
      timeout_q  <= 1'b0;
      fetch_q    <= 1'b0;
      regload_q  <= 1'b0;
      aluop_q    <= 1'b0;
      memload_q  <= 1'b0;
      memstore_q <= 1'b0;
      regstore_q <= 1'b0;
      next_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fetch_q    <= 1'b0;
      regload_q  <= 1'b0;
      aluop_q    <= 1'b0;
      memload_q  <= 1'b0;
      memstore_q <= 1'b0;
      regstore_q <= 1'b0;
      next_q     <= 1'b0;
      busy_q     <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.run) begin
            state   <= S_FETCH;
            fetch_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_FETCH: begin
          state     <= S_REGLOAD;
          regload_q <= 1'b1;
        end
        S_REGLOAD: begin
          state   <= S_EXEC;
          aluop_q <= bus.isaluop;
        end
        S_EXEC: begin
          if (op_in || op_out) begin
            state      <= S_MEMWAIT;
            memload_q  <= op_in;
            memstore_q <= op_out;
            wait_cnt   <= '0;
          end else if (writes_reg) begin
            state      <= S_REGSTORE;
            regstore_q <= 1'b1;
          end else begin
            state  <= S_NEXT;
            next_q <= 1'b1;
          end
        end
        S_MEMWAIT: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (op_in) begin
              state      <= S_REGSTORE;
              regstore_q <= 1'b1;
            end else begin
              state  <= S_NEXT;
              next_q <= 1'b1;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state     <= S_FAULT;
            wait_cnt  <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wait_cnt   <= wait_cnt + 1'b1;
            memload_q  <= op_in;
            memstore_q <= op_out;
          end
        end
        S_REGSTORE: begin
          state  <= S_NEXT;
          next_q <= 1'b1;
        end
        S_NEXT: begin
          retired_q <= retired_q + 1'b1;
          if (bus.run) begin
            state   <= S_FETCH;
            fetch_q <= 1'b1;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_FAULT: begin
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.do_fetch    = fetch_q;
  assign bus.do_regload  = regload_q;
  assign bus.do_aluop    = aluop_q;
  assign bus.do_memload  = memload_q;
  assign bus.do_memstore = memstore_q;
  assign bus.do_regstore = regstore_q;
  assign bus.do_next     = next_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;
  assign bus.retired     = retired_q;
  // br_taken is only valid once the instruction reaches NEXT, so it is not registered.
  assign bus.take_branch = next_q & (op_jmp | (op_br & bus.br_taken));

endmodule
